// File: rtl/dbg_snapshot_tx.sv
// Debug snapshot transmitter: on trigger, freezes the cycle counter plus NUM_WORDS words and streams them
// as a byte frame over a UART start/done handshake. Define DBG_SNAPSHOT_CHECKSUM_EN for a trailing XOR byte.
module dbg_snapshot_tx #(
    parameter int         WORD_BITS  = 32,
    parameter int         NUM_WORDS  = 16,
    parameter int         CYCLE_BITS = 32,
    parameter logic [7:0] HEADER     = 8'hA5,
    parameter bit         MSB_FIRST  = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_clk_en,
    input  logic                           i_count_clear,
    input  logic                           i_trigger,
    input  logic [NUM_WORDS*WORD_BITS-1:0] i_words,
    input  logic                           i_tx_done,
    output logic                           o_tx_start,
    output logic [7:0]                     o_tx_data,
    output logic                           o_busy,
    output logic                           o_frame_done,
    output logic [CYCLE_BITS-1:0]          o_cycle_count,
    output logic [7:0]                     o_dropped,
    output logic [2:0]                     o_state
);
    localparam int CB   = CYCLE_BITS / 8;
    localparam int WB   = WORD_BITS / 8;
    localparam int BODY = 2 + CB + NUM_WORDS * WB;
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
    localparam int T = BODY + 1;
`else
    localparam int T = BODY;
`endif
    localparam int IW = $clog2(T + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(T - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;

    logic [2:0]            r_state;
    logic [IW-1:0]         r_idx;
    logic [T*8-1:0]        r_frame;
    logic [CYCLE_BITS-1:0] r_count;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;
    logic                  r_frame_done;
    logic [7:0]            r_dropped;
    logic [T*8-1:0]        w_frame;
    logic [7:0]            w_csum;
    logic [IW-1:0]         w_next_idx;
    logic                  w_busy;

    // Whole frame is assembled in transmit order (byte 0 in the low bits) so capture is a single register load.
    always_comb begin
        w_frame        = '0;
        w_csum         = '0;
        w_frame[7:0]   = HEADER;
        w_frame[15:8]  = 8'(NUM_WORDS);
        for (int i = 0; i < CB; i++)
            w_frame[(2+i)*8 +: 8] = MSB_FIRST ? r_count[(CB-1-i)*8 +: 8] : r_count[i*8 +: 8];
        for (int k = 0; k < NUM_WORDS; k++)
            for (int i = 0; i < WB; i++)
                w_frame[(2+CB+k*WB+i)*8 +: 8] = MSB_FIRST ? i_words[k*WORD_BITS + (WB-1-i)*8 +: 8]
                                                          : i_words[k*WORD_BITS + i*8 +: 8];
        for (int i = 0; i < BODY; i++)
            w_csum = w_csum ^ w_frame[i*8 +: 8];
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
        w_frame[T*8-1 -: 8] = w_csum;
`endif
    end

    assign w_next_idx = r_idx + 1'b1;
    assign w_busy     = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_count <= '0;
        else if (i_count_clear)
            r_count <= '0;
        else if (i_clk_en)
            r_count <= r_count + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_frame      <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_frame_done <= 1'b0;
            r_dropped    <= '0;
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            if (i_trigger && w_busy && r_dropped != 8'hFF)
                r_dropped <= r_dropped + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (i_trigger) begin
                        r_frame    <= w_frame;
                        r_idx      <= '0;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_frame[7:0];
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: r_state <= S_WAIT;
                // A done pulse is only meaningful once the start pulse has retired.
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (r_idx == LAST_IDX) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= r_frame[w_next_idx*8 +: 8];
                            r_state    <= S_SEND;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_busy        = w_busy;
    assign o_frame_done  = r_frame_done;
    assign o_cycle_count = r_count;
    assign o_dropped     = r_dropped;
    assign o_state       = r_state;
endmodule
